// File: rtl/uart_pkt_parser_if.sv
// uart_pkt_parser_if: byte input stream and per-destination output strobes
// of the packet deframer. The master side feeds bytes and watches the
// verdicts; the slave side is the parser itself.
interface uart_pkt_parser_if #(
  parameter int N_SRC = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       master_data;
  logic [N_SRC-1:0] valid_bus;
  logic             pkt_done;
  logic             pkt_ok;
  logic [1:0]       err_code;
  logic             busy;

  modport master (
    output rx_data, rx_valid,
    input  master_data, valid_bus, pkt_done, pkt_ok, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output master_data, valid_bus, pkt_done, pkt_ok, err_code, busy
  );
endinterface

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: deframes PREFIX, addr, len, payload[len], checksum.
// Payload goes out as master_data plus a one-hot strobe for the addressed
// destination; each frame ends with a pkt_done verdict (ok / bad address /
// bad checksum / inter-byte timeout).
// Build option PKT_CRC_CHECK_EN: when defined the checksum byte (XOR of
// addr, len and payload) is verified; when undefined it is consumed and
// ignored and no XOR logic exists.
module uart_pkt_parser #(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] ADDR_BASE   = 8'h10,
  parameter logic [7:0] PREFIX      = 8'hDD,
  parameter int         TIMEOUT_CYC = 20000
) (
  input logic              clk,
  input logic              rst,
  uart_pkt_parser_if.slave bus
);
  localparam int          IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [8:0]  N_SRC_W  = 9'(N_SRC);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CRC} state_t;

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             addr_ok, addr_ok_n;
  logic [15:0]      tmo, tmo_n;
  logic [7:0]       mdata, mdata_n;
  logic [N_SRC-1:0] vbus, vbus_n;
  logic             done, done_n;
  logic             ok, ok_n;
  logic [1:0]       err, err_n;
  logic             busy_q, busy_n;
`ifdef PKT_CRC_CHECK_EN
  logic [7:0]       csum, csum_n;
`endif

  // Address offset; out-of-range addresses wrap to large unsigned values.
  logic [7:0] off;
  assign off = bus.rx_data - ADDR_BASE;

  // Next-state, counters and registered-output values.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    addr_ok_n = addr_ok;
    tmo_n     = tmo;
    mdata_n   = mdata;
    vbus_n    = '0;
    done_n    = 1'b0;
    ok_n      = 1'b0;
    err_n     = err;
`ifdef PKT_CRC_CHECK_EN
    csum_n    = csum;
`endif
    // Inter-byte watchdog: a byte arriving on the expiry cycle wins.
    if (state != S_IDLE && !bus.rx_valid) begin
      if (tmo == TMO_LAST) begin
        state_n = S_IDLE;
        tmo_n   = '0;
        done_n  = 1'b1;
        err_n   = 2'b11;
      end else begin
        tmo_n = tmo + 16'd1;
      end
    end
    if (bus.rx_valid) begin
      tmo_n = '0;
      case (state)
        S_IDLE: begin
          if (bus.rx_data == PREFIX) begin
            state_n = S_ADDR;
`ifdef PKT_CRC_CHECK_EN
            csum_n  = '0;
`endif
          end
        end
        S_ADDR: begin
          addr_ok_n = {1'b0, off} < N_SRC_W;
          idx_n     = off[IDX_W-1:0];
          state_n   = S_LEN;
`ifdef PKT_CRC_CHECK_EN
          csum_n    = csum ^ bus.rx_data;
`endif
        end
        S_LEN: begin
          cnt_n   = bus.rx_data;
          state_n = (bus.rx_data == 8'd0) ? S_CRC : S_DATA;
`ifdef PKT_CRC_CHECK_EN
          csum_n  = csum ^ bus.rx_data;
`endif
        end
        S_DATA: begin
          if (addr_ok) begin
            mdata_n = bus.rx_data;
            for (int k = 0; k < N_SRC; k++)
              if (idx == IDX_W'(k)) vbus_n[k] = 1'b1;
          end
          cnt_n = cnt - 8'd1;
          if (cnt == 8'd1) state_n = S_CRC;
`ifdef PKT_CRC_CHECK_EN
          csum_n = csum ^ bus.rx_data;
`endif
        end
        S_CRC: begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          if (!addr_ok) begin
            err_n = 2'b01;
`ifdef PKT_CRC_CHECK_EN
          end else if (bus.rx_data != csum) begin
            err_n = 2'b10;
`endif
          end else begin
            err_n = 2'b00;
            ok_n  = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    busy_n = (state_n != S_IDLE);
  end

  // State and output registers; reset aborts any frame without a verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      addr_ok <= 1'b0;
      tmo     <= '0;
      mdata   <= '0;
      vbus    <= '0;
      done    <= 1'b0;
      ok      <= 1'b0;
      err     <= 2'b00;
      busy_q  <= 1'b0;
`ifdef PKT_CRC_CHECK_EN
      csum    <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      addr_ok <= addr_ok_n;
      tmo     <= tmo_n;
      mdata   <= mdata_n;
      vbus    <= vbus_n;
      done    <= done_n;
      ok      <= ok_n;
      err     <= err_n;
      busy_q  <= busy_n;
`ifdef PKT_CRC_CHECK_EN
      csum    <= csum_n;
`endif
    end
  end

  assign bus.master_data = mdata;
  assign bus.valid_bus   = vbus;
  assign bus.pkt_done    = done;
  assign bus.pkt_ok      = ok;
  assign bus.err_code    = err;
  assign bus.busy        = busy_q;
endmodule
